// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1-2 stop bits.
// Latency: start bit appears on tx_serial the cycle after the accepting edge; frame is N*CLKS_PER_BIT clks.
// Backpressure: tx_ready is high only in IDLE; tx_dv while busy is dropped, never queued.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_dv,
    input  logic [DATA_BITS-1:0] tx_byte,
    output logic                 tx_ready,
    output logic                 tx_active,
    output logic                 tx_serial,
    output logic                 tx_done
);

    // Bit-time counter width; the max() guard keeps a legal 1-bit counter if CLKS_PER_BIT is misconfigured.
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    // Index counter is one bit wider than needed so it never wraps while counting data bits.
    localparam int IW = $clog2(DATA_BITS) + 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    // Reject parameter combinations the frame logic was not built for.
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [CW-1:0]         clk_cnt;
    logic [IW-1:0]         bit_idx;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  parity_bit;
    logic                  bit_end;

    // Last clock of the current bit period.
    assign bit_end = (clk_cnt == CNT_LAST);

    // Frame sequencer: every output is registered so tx_serial is glitch-free toward the pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_serial  <= 1'b1;
            tx_active  <= 1'b0;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_serial <= 1'b1;
                    clk_cnt   <= '0;
                    bit_idx   <= '0;
                    if (tx_dv && tx_ready) begin
                        // Word and its parity are frozen here; later tx_byte changes are ignored.
                        shift_reg  <= tx_byte;
                        parity_bit <= (PARITY == 1) ? ~^tx_byte : ^tx_byte;
                        tx_serial  <= 1'b0;
                        tx_active  <= 1'b1;
                        tx_ready   <= 1'b0;
                        state      <= S_START;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        tx_serial <= shift_reg[0];
                        state     <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                tx_serial <= parity_bit;
                                state     <= S_PARITY;
                            end else begin
                                tx_serial <= 1'b1;
                                state     <= S_STOP;
                            end
                        end else begin
                            // Shift right so the next data bit is always at [1] -> [0].
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx_serial <= shift_reg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        tx_serial <= 1'b1;
                        state     <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            // Frame complete: done and ready rise together, active falls.
                            bit_idx   <= '0;
                            tx_done   <= 1'b1;
                            tx_active <= 1'b0;
                            tx_ready  <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    tx_serial <= 1'b1;
                    tx_active <= 1'b0;
                    tx_ready  <= 1'b1;
                    clk_cnt   <= '0;
                    bit_idx   <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
